// File: rtl/ram_ctrl_if.sv
// Request/response handshake plus ram-side bus for ram_ctrl.
// slave = the controller's view; master = requester/ram-model view.
interface ram_ctrl_if #(
  parameter int word_size = 27,
  parameter int addr_size = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [addr_size-1:0] req_addr;
  logic [word_size-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [word_size-1:0] rsp_rdata;
  logic                 rsp_err;
  logic [addr_size-1:0] ram_address;
  logic                 ram_select;
  logic                 ram_operation;
  logic [word_size-1:0] ram_wdata;
  logic [word_size-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ram_address, ram_select, ram_operation, ram_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ram_address, ram_select, ram_operation, ram_wdata
  );
endinterface

// File: rtl/ram_ctrl.sv
// Single-outstanding request sequencer for the ram: setup, one-cycle
// select pulse, release, then a held response. Out-of-range addresses
// are answered with an error and never touch the ram.
module ram_ctrl #(
  parameter int word_size   = 27,
  parameter int word_amount = 37,
  localparam int addr_size  = $clog2(word_amount)
) (
  input  logic     clk,
  input  logic     rst,
  ram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RELEASE, RESP} state_e;

  // one extra bit so the compare is unsigned and covers the full range
  localparam logic [addr_size:0] amt = word_amount[addr_size:0];

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;       // request latched, not yet dispatched
  logic                 op_q, op_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] wdata_q, wdata_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [word_size-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 ram_sel_q, ram_sel_d;
  logic                 ram_op_q, ram_op_d;
  logic [addr_size-1:0] ram_addr_q, ram_addr_d;
  logic [word_size-1:0] ram_wdata_q, ram_wdata_d;

  logic accept;
  logic addr_err;

  assign accept   = (state_q == IDLE) && req_ready_q && bus.req_valid;
  assign addr_err = ({1'b0, addr_q} >= amt);

  // state and all registered outputs; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_sel_q   <= 1'b0;
      ram_op_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_sel_q   <= ram_sel_d;
      ram_op_q    <= ram_op_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // next state: a latched request is dispatched one cycle after accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_q) state_d = addr_err ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = RELEASE;
      RELEASE: state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the latched request and every registered output
  always_comb begin
    pend_d      = accept;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_op_d    = ram_op_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (accept) begin
      op_d    = bus.req_op;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end

    // ram bus only moves on entry to SETUP; held through RELEASE and after
    if (state_q == IDLE && state_d == SETUP) begin
      ram_addr_d  = addr_q;
      ram_op_d    = op_q;
      ram_wdata_d = op_q ? wdata_q : '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end

    if (state_q == IDLE && state_d == RESP) begin
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end

    // read data is captured on the edge that ends the select pulse
    if (state_q == ACCESS)
      rsp_rdata_d = op_q ? '0 : bus.ram_rdata;

    ram_sel_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE) && !pend_d;
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.ram_select    = ram_sel_q;
  assign bus.ram_operation = ram_op_q;
  assign bus.ram_address   = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;

endmodule
